// File: rtl/fan_pwm_gen.sv
// Fan PWM generator: saturates and floors the PID output, updates duty/period only at period wraps, and kick-starts the fan at full on.
// Outputs are registered, updating on the enabled tick; no backpressure, so every pid_valid_i strobe is accepted.
module fan_pwm_gen #(
    parameter int ADC_BITWIDTH  = 8,
    parameter int KICK_BITWIDTH = 4
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic                            clk_en_i,
    input  logic signed [ADC_BITWIDTH:0]    pid_val_i,
    input  logic                            pid_valid_i,
    input  logic        [ADC_BITWIDTH:0]    period_i,
    input  logic        [ADC_BITWIDTH-1:0]  min_duty_i,
    input  logic        [KICK_BITWIDTH-1:0] kick_periods_i,
    output logic                            pwm_o,
    output logic        [ADC_BITWIDTH-1:0]  duty_o,
    output logic                            period_end_o,
    output logic        [1:0]               state_o
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_KICK = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [ADC_BITWIDTH:0]    CNT_ONE  = 1;
    localparam logic [KICK_BITWIDTH-1:0] KICK_ONE = 1;

    logic [ADC_BITWIDTH:0]    cnt_q,   cnt_d;
    logic [ADC_BITWIDTH:0]    per_q,   per_d;
    logic [ADC_BITWIDTH-1:0]  pend_q,  pend_d;
    logic [ADC_BITWIDTH-1:0]  duty_q,  duty_d;
    logic [KICK_BITWIDTH-1:0] kick_q,  kick_d;
    state_t                   state_q, state_d;
    logic                     pwm_q,   pwm_d;
    logic                     pe_q,    pe_d;

    logic                     wrap;
    logic [ADC_BITWIDTH-1:0]  sat_duty;
    logic [ADC_BITWIDTH-1:0]  floor_duty;
    logic [ADC_BITWIDTH:0]    per_clamped;

    // A signed (W+1)-bit value that is non-negative always fits in W bits,
    // so only the negative side needs clamping.
    assign sat_duty    = pid_val_i[ADC_BITWIDTH] ? '0 : pid_val_i[ADC_BITWIDTH-1:0];
    assign floor_duty  = (pend_q == '0)        ? '0 :
                         (pend_q < min_duty_i) ? min_duty_i : pend_q;
    assign per_clamped = (period_i == '0) ? CNT_ONE : period_i;
    assign wrap        = clk_en_i && (cnt_q == per_q);

    always_comb begin
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        duty_d  = duty_q;
        kick_d  = kick_q;
        state_d = state_q;
        pwm_d   = pwm_q;
        pe_d    = wrap;

        if (pid_valid_i) begin
            pend_d = sat_duty;
        end

        if (clk_en_i) begin
            cnt_d = cnt_q + CNT_ONE;
        end

        if (wrap) begin
            cnt_d  = '0;
            per_d  = per_clamped;
            duty_d = floor_duty;
            unique case (state_q)
                ST_OFF: begin
                    if (floor_duty != '0) begin
                        if (kick_periods_i != '0) begin
                            state_d = ST_KICK;
                            kick_d  = kick_periods_i;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_KICK: begin
                    if (floor_duty == '0) begin
                        state_d = ST_OFF;
                        kick_d  = '0;
                    end else begin
                        kick_d = kick_q - KICK_ONE;
                        if (kick_d == '0) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (floor_duty == '0) begin
                        state_d = ST_OFF;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end

        // Pin is computed from next-state values so it lines up with cnt_q.
        if (clk_en_i) begin
            unique case (state_d)
                ST_KICK: pwm_d = 1'b1;
                ST_RUN:  pwm_d = (cnt_d < {1'b0, duty_d});
                default: pwm_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q   <= '0;
            per_q   <= '0;
            pend_q  <= '0;
            duty_q  <= '0;
            kick_q  <= '0;
            state_q <= ST_OFF;
            pwm_q   <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            pend_q  <= pend_d;
            duty_q  <= duty_d;
            kick_q  <= kick_d;
            state_q <= state_d;
            pwm_q   <= pwm_d;
            pe_q    <= pe_d;
        end
    end

    assign pwm_o        = pwm_q;
    assign duty_o       = duty_q;
    assign period_end_o = pe_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_fan_pwm_gen.sv
// Scoreboard bench for fan_pwm_gen: stimulus pushes the expected outcome of each period wrap,
// the monitor checks duty/state at each period_end_o pulse plus the tick and high counts of the period that ended.
module tb_fan_pwm_gen;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              clk_en_i;
    logic signed [8:0] pid_val_i;
    logic              pid_valid_i;
    logic [8:0]        period_i;
    logic [7:0]        min_duty_i;
    logic [3:0]        kick_periods_i;
    logic              pwm_o;
    logic [7:0]        duty_o;
    logic              period_end_o;
    logic [1:0]        state_o;

    fan_pwm_gen #(.ADC_BITWIDTH(8), .KICK_BITWIDTH(4)) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .clk_en_i       (clk_en_i),
        .pid_val_i      (pid_val_i),
        .pid_valid_i    (pid_valid_i),
        .period_i       (period_i),
        .min_duty_i     (min_duty_i),
        .kick_periods_i (kick_periods_i),
        .pwm_o          (pwm_o),
        .duty_o         (duty_o),
        .period_end_o   (period_end_o),
        .state_o        (state_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int duty;
        int state;
        int len;   // ticks in the period that just ended, -1 = not checked
        int hi;    // pwm-high ticks in that period, -1 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   wrap_no = 0;
    int   len_cnt = 0;
    int   hi_cnt  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: one tick is consumed per negedge that sees clk_en_i high.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            len_cnt = 0;
            hi_cnt  = 0;
        end else begin
            if (period_end_o) begin
                wrap_no++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_wrap%0d: duty %0d state %0d, no wrap expected",
                             wrap_no, duty_o, state_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("wrap%0d_duty", wrap_no), int'(duty_o), e.duty);
                    chk($sformatf("wrap%0d_state", wrap_no), int'(state_o), e.state);
                    if (e.len >= 0) chk($sformatf("wrap%0d_period_len", wrap_no), len_cnt, e.len);
                    if (e.hi >= 0)  chk($sformatf("wrap%0d_high_ticks", wrap_no), hi_cnt, e.hi);
                end
                len_cnt = 0;
                hi_cnt  = 0;
            end
            if (clk_en_i) begin
                len_cnt++;
                if (pwm_o) hi_cnt++;
            end
        end
    end

    task automatic push(input int duty, input int state, input int len, input int hi);
        exp_t e;
        e.duty = duty; e.state = state; e.len = len; e.hi = hi;
        exp_q.push_back(e);
    endtask

    task automatic capture(input int v);
        pid_val_i   = 9'(v);
        pid_valid_i = 1'b1;
        @(posedge clk_i); #2;
        pid_valid_i = 1'b0;
    endtask

    // Runs enabled until all pushed wraps are seen, then freezes the counter.
    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge clk_i); #2;
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d expected wraps not seen", exp_q.size());
            exp_q.delete();
        end
        clk_en_i = 1'b0;
    endtask

    task automatic step(input bit do_pid, input int v, input int duty, input int state,
                        input int len, input int hi);
        if (do_pid) capture(v);
        push(duty, state, len, hi);
        clk_en_i = 1'b1;
        wait_drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rstn_i = 1'b0; clk_en_i = 1'b0; pid_val_i = '0; pid_valid_i = 1'b0;
        period_i = 9'd3; min_duty_i = 8'd0; kick_periods_i = 4'd0;
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_pwm", int'(pwm_o), 0);
        chk("rst_state", int'(state_o), 0);
        chk("rst_duty", int'(duty_o), 0);
        chk("rst_period_end", int'(period_end_o), 0);
        rstn_i = 1'b1;
        @(posedge clk_i); #2;

        // Saturation; first enabled tick after reset wraps immediately.
        // +300 does not fit the signed 9-bit port, so +255 is the top of range.
        step(1, -5,   0,   0, -1, -1);
        step(1, 255,  255, 2, 4,  0);
        step(1, 100,  100, 2, 4,  4);
        step(1, -256, 0,   0, 4,  4);

        // Minimum-duty floor, captured while clk_en_i is low.
        min_duty_i = 8'd40;
        step(1, 10, 40, 2, 4, 0);
        step(1, 0,  0,  0, 4, 4);
        step(1, 40, 40, 2, 4, 0);
        step(1, 39, 40, 2, 4, 4);
        step(1, 0,  0,  0, 4, 4);
        min_duty_i = 8'd0;

        // Kick: two full-on periods, then RUN with duty > period.
        kick_periods_i = 4'd2;
        period_i = 9'd9;
        step(1, 50, 50, 1, 4,  0);
        step(0, 0,  50, 1, 10, 10);
        step(0, 0,  50, 2, 10, 10);
        step(0, 0,  50, 2, 10, 10);

        // Duty waveform: 3 high of 10.
        step(1, 3, 3, 2, 10, 10);
        step(0, 0, 3, 2, 10, 3);
        step(0, 0, 3, 2, 10, 3);
        step(1, 5, 5, 2, 10, 3);

        // Counter is frozen at 1 with period 9: the 9th enabled edge is a wrap.
        push(5, 2, 10, 5);
        push(7, 2, 10, 5);
        pid_val_i = 9'sd7;
        clk_en_i = 1'b1;
        repeat (8) @(posedge clk_i);
        #2;
        pid_valid_i = 1'b1;
        @(posedge clk_i); #2;
        pid_valid_i = 1'b0;
        wait_drain();

        // Hold with clk_en_i low: frozen at cnt=1, duty 7, RUN.
        repeat (5) @(posedge clk_i);
        #2;
        chk("hold_pwm", int'(pwm_o), 1);
        chk("hold_state", int'(state_o), 2);
        chk("hold_duty", int'(duty_o), 7);

        // Enter KICK, then reset part-way through it.
        kick_periods_i = 4'd3;
        step(1, 0,  0,  0, 10, 7);
        step(1, 50, 50, 1, 10, 0);
        clk_en_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #2;
        chk("kick_pwm", int'(pwm_o), 1);
        chk("kick_state", int'(state_o), 1);
        rstn_i = 1'b0;
        #1;
        chk("async_rst_pwm", int'(pwm_o), 0);
        chk("async_rst_state", int'(state_o), 0);
        chk("async_rst_duty", int'(duty_o), 0);
        clk_en_i = 1'b0;
        period_i = 9'd0;
        kick_periods_i = 4'd0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #2;
        rstn_i = 1'b1;
        @(posedge clk_i); #2;

        // Period 0 is clamped to 1, giving a 2-tick period.
        step(1, 5, 5, 2, -1, -1);
        step(0, 0, 5, 2, 2,  2);
        step(0, 0, 5, 2, 2,  2);

        repeat (3) @(posedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
